hosted_mem_arbiter: RTL and testbench

HOSTED_MEM_ARBITER -- requirements
Module: hosted_mem_arbiter

---
 rtl/hosted_mem_arbiter_pkg.sv | 17 +
 rtl/hosted_tag_fifo.sv | 44 ++++
 rtl/hosted_mem_arbiter.sv | 117 +++++++++++
 tb/tb_hosted_mem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hosted_mem_arbiter_pkg.sv
// Shared types and width helpers for the hosted memory arbiter and its tag FIFO.
package hosted_mem_arbiter_pkg;

    localparam int MAX_PORTS = 8;

    typedef logic [$clog2(MAX_PORTS)-1:0] port_idx_t;

    function automatic int port_idx_w(input int n_ports);
        return (n_ports > 1) ? $clog2(n_ports) : 1;
    endfunction

    // One extra MSB distinguishes full from empty when the index bits match.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hosted_tag_fifo.sv
// In-order tag FIFO holding the port index of every accepted-but-unanswered request.
module hosted_tag_fifo
    import hosted_mem_arbiter_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = fifo_ptr_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign dout  = mem[rd_ptr[PW-2:0]];

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push && !srst) mem[wr_ptr[PW-2:0]] <= din;
    end

endmodule

// File: rtl/hosted_mem_arbiter.sv
// Round-robin arbiter funnelling N request ports into one registered memory port,
// routing in-order memory responses back to the originating port via a tag FIFO.
module hosted_mem_arbiter
    import hosted_mem_arbiter_pkg::*;
#(
    parameter int N_PORTS   = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                              clk,
    input  logic                              srst,
    input  logic [N_PORTS-1:0]                req_valid,
    output logic [N_PORTS-1:0]                req_ready,
    input  logic [N_PORTS-1:0][ADDR_W-1:0]    req_addr,
    input  logic [N_PORTS-1:0]                req_write,
    input  logic [N_PORTS-1:0][DATA_W-1:0]    req_wdata,
    input  logic [N_PORTS-1:0][DATA_W/8-1:0]  req_wstrb,
    output logic [N_PORTS-1:0]                rsp_valid,
    output logic [DATA_W-1:0]                 rsp_rdata,
    output logic                              rsp_err,
    output logic                              mem_valid,
    input  logic                              mem_ready,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic                              mem_write,
    output logic [DATA_W-1:0]                 mem_wdata,
    output logic [DATA_W/8-1:0]               mem_wstrb,
    input  logic                              mem_rvalid,
    input  logic [DATA_W-1:0]                 mem_rdata,
    input  logic                              mem_rerr
);

    localparam int IDX_W = port_idx_w(N_PORTS);

    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand_idx;
    logic [IDX_W-1:0] head_tag;
    logic             grant_any;
    logic             out_free;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             accept;
    logic             orphan_rsp;
    int               cand;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= N_PORTS) cand = cand - N_PORTS;
            cand_idx = IDX_W'(cand);
            if (!grant_any && req_valid[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    assign out_free = !mem_valid || mem_ready;
    assign fifo_pop = mem_rvalid && !fifo_empty && !srst;
    // A response retiring this cycle frees a tag slot for a grant in the same cycle.
    assign accept   = grant_any && out_free && (!fifo_full || fifo_pop) && !srst;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        rsp_valid = '0;
        if (fifo_pop) rsp_valid[head_tag] = 1'b1;
    end

    assign rsp_rdata = mem_rdata;
    assign rsp_err   = mem_rerr;

    always_ff @(posedge clk) begin
        if (srst) begin
            mem_valid  <= 1'b0;
            last_grant <= IDX_W'(N_PORTS - 1);
            orphan_rsp <= 1'b0;
        end else begin
            if (accept) begin
                mem_valid  <= 1'b1;
                mem_addr   <= req_addr[grant_idx];
                mem_write  <= req_write[grant_idx];
                mem_wdata  <= req_wdata[grant_idx];
                mem_wstrb  <= req_wstrb[grant_idx];
                last_grant <= grant_idx;
            end else if (mem_ready) begin
                mem_valid <= 1'b0;
            end
            orphan_rsp <= orphan_rsp | (mem_rvalid & fifo_empty);
        end
    end

    hosted_tag_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk   (clk),
        .srst  (srst),
        .push  (accept),
        .din   (grant_idx),
        .pop   (fifo_pop),
        .dout  (head_tag),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_hosted_mem_arbiter.sv
// Scenario bench for hosted_mem_arbiter: expected response tags are queued as requests are accepted.
module tb_hosted_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic                   clk = 1'b0;
    logic                   srst;
    logic [N-1:0]           req_valid;
    logic [N-1:0]           req_ready;
    logic [N-1:0][AW-1:0]   req_addr;
    logic [N-1:0]           req_write;
    logic [N-1:0][DW-1:0]   req_wdata;
    logic [N-1:0][SW-1:0]   req_wstrb;
    logic [N-1:0]           rsp_valid;
    logic [DW-1:0]          rsp_rdata;
    logic                   rsp_err;
    logic                   mem_valid;
    logic                   mem_ready;
    logic [AW-1:0]          mem_addr;
    logic                   mem_write;
    logic [DW-1:0]          mem_wdata;
    logic [SW-1:0]          mem_wstrb;
    logic                   mem_rvalid;
    logic [DW-1:0]          mem_rdata;
    logic                   mem_rerr;

    int n_checks = 0;
    int n_pass   = 0;
    int n_push   = 0;
    int sb_q[$];

    hosted_mem_arbiter #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(4)) dut (
        .clk(clk), .srst(srst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rerr(mem_rerr)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] port_addr(input int p);
        return 32'h0000_1000 + 32'(p) * 32'h100;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid  = '0;
        req_write  = '0;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        mem_rerr   = 1'b0;
        for (int p = 0; p < N; p++) begin
            req_addr[p]  = port_addr(p);
            req_wdata[p] = 32'hC0DE_0000 + 32'(p);
            req_wstrb[p] = '1;
        end
    endtask

    task automatic drain_responses();
        int tag;
        logic [DW-1:0] d;
        while (sb_q.size() > 0) begin
            req_valid  = '0;
            mem_rvalid = 1'b1;
            d          = $urandom;
            mem_rdata  = d;
            #1;
            tag = sb_q.pop_front();
            n_checks++;
            if (rsp_valid !== 3'(1 << tag))
                $display("FAIL drain_rsp_valid got %b want %b", rsp_valid, 3'(1 << tag));
            else n_pass++;
            n_checks++;
            if (rsp_rdata !== d) $display("FAIL drain_rsp_rdata got %h want %h", rsp_rdata, d);
            else n_pass++;
            step();
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        srst = 1'b1;
        step();
        step();
        #1;
        n_checks++;
        if (mem_valid !== 1'b0) $display("FAIL reset_mem_valid got %b want 0", mem_valid);
        else n_pass++;
        n_checks++;
        if (req_ready !== 3'b000) $display("FAIL reset_req_ready got %b want 000", req_ready);
        else n_pass++;
        n_checks++;
        if (rsp_valid !== 3'b000) $display("FAIL reset_rsp_valid got %b want 000", rsp_valid);
        else n_pass++;
        n_checks++;
        if (dut.orphan_rsp !== 1'b0) $display("FAIL reset_orphan got %b want 0", dut.orphan_rsp);
        else n_pass++;
        srst      = 1'b0;
        n_push    = 0;
        sb_q.delete();
        req_valid = 3'b111;
        #1;
        n_checks++;
        if (req_ready !== 3'b001) $display("FAIL reset_first_grant got %b want 001", req_ready);
        else n_pass++;
        req_valid = '0;
        step();
    endtask

    task automatic test_fairness();
        int fair_exp[6] = '{0, 1, 2, 0, 1, 2};
        int tag;
        for (int i = 0; i < 6; i++) begin
            req_valid  = 3'b111;
            mem_ready  = 1'b1;
            mem_rvalid = (sb_q.size() > 0);
            mem_rdata  = 32'h100 + 32'(i);
            #1;
            n_checks++;
            if (req_ready !== 3'(1 << fair_exp[i]))
                $display("FAIL fair_grant cycle %0d got %b want %b", i, req_ready, 3'(1 << fair_exp[i]));
            else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (mem_valid !== 1'b1 || mem_addr !== port_addr(fair_exp[i-1]))
                    $display("FAIL fair_mem_addr cycle %0d got %b/%h want 1/%h", i, mem_valid, mem_addr,
                             port_addr(fair_exp[i-1]));
                else n_pass++;
            end
            if (mem_rvalid) begin
                tag = sb_q.pop_front();
                n_checks++;
                if (rsp_valid !== 3'(1 << tag))
                    $display("FAIL fair_rsp_valid cycle %0d got %b want %b", i, rsp_valid, 3'(1 << tag));
                else n_pass++;
                n_checks++;
                if (rsp_rdata !== 32'h100 + 32'(i))
                    $display("FAIL fair_rsp_rdata cycle %0d got %h want %h", i, rsp_rdata, 32'h100 + 32'(i));
                else n_pass++;
            end
            step();
            sb_q.push_back(fair_exp[i]);
            n_push++;
        end
        drain_responses();
    endtask

    task automatic test_backpressure();
        idle_inputs();
        req_valid    = 3'b010;
        req_write    = 3'b010;
        req_addr[1]  = 32'h2000_0010;
        req_wdata[1] = 32'hDEAD_BEEF;
        req_wstrb[1] = 4'b0110;
        #1;
        n_checks++;
        if (req_ready !== 3'b010) $display("FAIL bp_accept got %b want 010", req_ready);
        else n_pass++;
        step();
        sb_q.push_back(1);
        n_push++;
        mem_ready = 1'b0;
        req_valid = 3'b111;
        for (int i = 0; i < 5; i++) begin
            req_addr[1]  = 32'h3000_0000 + 32'(i);
            req_wdata[1] = 32'h1111_0000 + 32'(i);
            #1;
            n_checks++;
            if (req_ready !== 3'b000) $display("FAIL bp_req_ready cycle %0d got %b want 000", i, req_ready);
            else n_pass++;
            n_checks++;
            if (mem_valid !== 1'b1 || mem_addr !== 32'h2000_0010 || mem_write !== 1'b1 ||
                mem_wdata !== 32'hDEAD_BEEF || mem_wstrb !== 4'b0110)
                $display("FAIL bp_payload cycle %0d got %b/%h/%b/%h/%b want 1/20000010/1/deadbeef/0110",
                         i, mem_valid, mem_addr, mem_write, mem_wdata, mem_wstrb);
            else n_pass++;
            n_checks++;
            if (dut.u_tag_fifo.wr_ptr !== 3'(n_push))
                $display("FAIL bp_no_push cycle %0d got %0d want %0d", i, dut.u_tag_fifo.wr_ptr, 3'(n_push));
            else n_pass++;
            step();
        end
        req_valid = '0;
        mem_ready = 1'b1;
        step();
        n_checks++;
        if (mem_valid !== 1'b0) $display("FAIL bp_release got %b want 0", mem_valid);
        else n_pass++;
        idle_inputs();
        drain_responses();
    endtask

    task automatic test_full();
        int tag;
        idle_inputs();
        req_valid = 3'b001;
        for (int i = 0; i < 4; i++) begin
            req_addr[0] = 32'h4000 + 32'(i * 4);
            #1;
            n_checks++;
            if (req_ready !== 3'b001) $display("FAIL full_accept %0d got %b want 001", i, req_ready);
            else n_pass++;
            step();
            sb_q.push_back(0);
            n_push++;
        end
        #1;
        n_checks++;
        if (req_ready !== 3'b000) $display("FAIL full_stall got %b want 000", req_ready);
        else n_pass++;
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55;
        #1;
        n_checks++;
        if (req_ready !== 3'b001) $display("FAIL full_same_cycle_pop got %b want 001", req_ready);
        else n_pass++;
        tag = sb_q.pop_front();
        n_checks++;
        if (rsp_valid !== 3'(1 << tag)) $display("FAIL full_rsp_valid got %b want %b", rsp_valid, 3'(1 << tag));
        else n_pass++;
        step();
        sb_q.push_back(0);
        n_push++;
        mem_rvalid = 1'b0;
        req_valid  = '0;
        drain_responses();
    endtask

    task automatic test_ordering();
        int tag;
        idle_inputs();
        req_valid = 3'b100;
        #1;
        n_checks++;
        if (req_ready !== 3'b100) $display("FAIL ord_accept2 got %b want 100", req_ready);
        else n_pass++;
        step();
        sb_q.push_back(2);
        req_valid = 3'b001;
        #1;
        n_checks++;
        if (req_ready !== 3'b001) $display("FAIL ord_accept0 got %b want 001", req_ready);
        else n_pass++;
        step();
        sb_q.push_back(0);
        req_valid = '0;
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hA;
        mem_rerr   = 1'b0;
        #1;
        tag = sb_q.pop_front();
        n_checks++;
        if (rsp_valid !== 3'(1 << tag) || rsp_rdata !== 32'hA || rsp_err !== 1'b0)
            $display("FAIL ord_first got %b/%h/%b want %b/a/0", rsp_valid, rsp_rdata, rsp_err, 3'(1 << tag));
        else n_pass++;
        step();
        mem_rdata = 32'hB;
        mem_rerr  = 1'b1;
        #1;
        tag = sb_q.pop_front();
        n_checks++;
        if (rsp_valid !== 3'(1 << tag) || rsp_rdata !== 32'hB || rsp_err !== 1'b1)
            $display("FAIL ord_second got %b/%h/%b want %b/b/1", rsp_valid, rsp_rdata, rsp_err, 3'(1 << tag));
        else n_pass++;
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (rsp_valid !== 3'b000) $display("FAIL ord_idle got %b want 000", rsp_valid);
        else n_pass++;
    endtask

    task automatic test_orphan();
        idle_inputs();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h77;
        #1;
        n_checks++;
        if (rsp_valid !== 3'b000) $display("FAIL orphan_no_pulse got %b want 000", rsp_valid);
        else n_pass++;
        step();
        mem_rvalid = 1'b0;
        #1;
        n_checks++;
        if (dut.orphan_rsp !== 1'b1) $display("FAIL orphan_set got %b want 1", dut.orphan_rsp);
        else n_pass++;
        step();
        n_checks++;
        if (dut.orphan_rsp !== 1'b1) $display("FAIL orphan_sticky got %b want 1", dut.orphan_rsp);
        else n_pass++;
        srst = 1'b1;
        step();
        srst = 1'b0;
        #1;
        n_checks++;
        if (dut.orphan_rsp !== 1'b0) $display("FAIL orphan_cleared got %b want 0", dut.orphan_rsp);
        else n_pass++;
        req_valid = 3'b001;
        #1;
        n_checks++;
        if (req_ready !== 3'b001) $display("FAIL orphan_accept got %b want 001", req_ready);
        else n_pass++;
        step();
        req_valid = '0;
        srst      = 1'b1;
        step();
        srst       = 1'b0;
        mem_rvalid = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid !== 3'b000) $display("FAIL midreset_no_pulse got %b want 000", rsp_valid);
        else n_pass++;
        n_checks++;
        if (mem_valid !== 1'b0) $display("FAIL midreset_mem_valid got %b want 0", mem_valid);
        else n_pass++;
        step();
        mem_rvalid = 1'b0;
        n_checks++;
        if (dut.orphan_rsp !== 1'b1) $display("FAIL midreset_orphan got %b want 1", dut.orphan_rsp);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        srst = 1'b1;
        idle_inputs();
        test_reset();
        test_fairness();
        test_backpressure();
        test_full();
        test_ordering();
        test_orphan();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
